// File: rtl/player_cannon_if.sv
// Player-ship bundle: game controls and enemy shot in, ship/shot/status out.
// Clock and reset are not part of the bundle.
interface player_cannon_if;
    logic       play;
    logic       btn_left;
    logic       btn_right;
    logic       btn_fire;
    logic       enemy_hit;
    logic [9:0] enemy_projectiles_x;
    logic [9:0] enemy_projectiles_y;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [9:0] projectiles_x;
    logic [9:0] projectiles_y;
    logic       hit;
    logic [1:0] lives;
    logic       game_over;
    logic       visible;

    modport master (
        output play, btn_left, btn_right, btn_fire, enemy_hit,
               enemy_projectiles_x, enemy_projectiles_y,
        input  player_x, player_y, projectiles_x, projectiles_y,
               hit, lives, game_over, visible
    );

    modport slave (
        input  play, btn_left, btn_right, btn_fire, enemy_hit,
               enemy_projectiles_x, enemy_projectiles_y,
        output player_x, player_y, projectiles_x, projectiles_y,
               hit, lives, game_over, visible
    );
endinterface

// File: rtl/player_cannon.sv
// Player cannon: ship movement, single player shot, enemy-shot collision,
// lives and post-hit invulnerability with sprite blink.
module player_cannon #(
    parameter logic [9:0]  X_MIN         = 10'd10,
    parameter logic [9:0]  X_MAX         = 10'd630,
    parameter logic [9:0]  Y_POS         = 10'd440,
    parameter logic [9:0]  PROJ_STEP     = 10'd4,
    parameter logic [1:0]  LIVES_INIT    = 2'd3,
    parameter logic [15:0] INVULN_CYCLES = 16'd1024
) (
    input  logic            clk_4,
    input  logic            clr,
    player_cannon_if.slave  bus
);
    localparam logic [10:0] X_SUM = {1'b0, X_MIN} + {1'b0, X_MAX};
    localparam logic [9:0]  X_CTR = X_SUM[10:1];
    localparam logic [9:0]  Y_LO  = Y_POS - 10'd10;
    localparam logic [9:0]  Y_HI  = Y_POS + 10'd10;

    typedef enum logic [1:0] {IDLE, ALIVE, HIT, DEAD} state_t;

    state_t      state, state_nx;
    logic [9:0]  px, px_nx, sx, sx_nx, sy, sy_nx;
    logic [1:0]  lives_r, lives_nx;
    logic [1:0]  mv_cnt;
    logic        hit_r, hit_nx;
    logic        fire_q;
    logic [15:0] inv_cnt, inv_nx;

    logic [9:0]  dx;
    logic        hit_det, accept, fire_rise, fire_ok, move_ok;

    // Distance taken as larger-minus-smaller so the unsigned difference never wraps.
    assign dx = (bus.enemy_projectiles_x >= px) ? (bus.enemy_projectiles_x - px)
                                                : (px - bus.enemy_projectiles_x);
    assign hit_det = (bus.enemy_projectiles_y != 10'd0) &&
                     (bus.enemy_projectiles_y >= Y_LO) &&
                     (bus.enemy_projectiles_y <= Y_HI) &&
                     (dx < 10'd10);
    assign accept    = bus.play && (state == ALIVE) && hit_det;
    assign fire_rise = bus.btn_fire && !fire_q;
    assign fire_ok   = bus.play && fire_rise && (state == ALIVE) && (sy == 10'd0) && !accept;
    assign move_ok   = (mv_cnt == 2'd3) && ((state == ALIVE) || (state == HIT));

    always_comb begin
        state_nx = state;
        px_nx    = px;
        sx_nx    = sx;
        sy_nx    = sy;
        lives_nx = lives_r;
        hit_nx   = 1'b0;
        inv_nx   = inv_cnt;
        if (!bus.play) begin
            state_nx = IDLE;
            px_nx    = X_CTR;
            sx_nx    = 10'd0;
            sy_nx    = 10'd0;
            lives_nx = LIVES_INIT;
            inv_nx   = 16'd0;
        end else begin
            case (state)
                IDLE: state_nx = ALIVE;
                ALIVE, HIT: begin
                    if (move_ok) begin
                        if (bus.btn_left && !bus.btn_right && (px > X_MIN))
                            px_nx = px - 10'd1;
                        else if (bus.btn_right && !bus.btn_left && (px < X_MAX))
                            px_nx = px + 10'd1;
                    end
                    // A live shot blocks firing, including on the cycle it retires.
                    if (sy != 10'd0) begin
                        if (bus.enemy_hit || (sy <= PROJ_STEP)) begin
                            sx_nx = 10'd0;
                            sy_nx = 10'd0;
                        end else begin
                            sy_nx = sy - PROJ_STEP;
                        end
                    end else if (fire_ok) begin
                        sx_nx = px;
                        sy_nx = Y_POS - 10'd1;
                    end
                    if (state == HIT) begin
                        if (inv_cnt == 16'd0) state_nx = ALIVE;
                        else                  inv_nx   = inv_cnt - 16'd1;
                    end else if (accept) begin
                        hit_nx   = 1'b1;
                        lives_nx = lives_r - 2'd1;
                        inv_nx   = INVULN_CYCLES - 16'd1;
                        if (lives_r == 2'd1) begin
                            state_nx = DEAD;
                            lives_nx = 2'd0;
                            sx_nx    = 10'd0;
                            sy_nx    = 10'd0;
                        end else begin
                            state_nx = HIT;
                        end
                    end
                end
                DEAD: state_nx = DEAD;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_4 or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            px      <= X_CTR;
            sx      <= 10'd0;
            sy      <= 10'd0;
            lives_r <= LIVES_INIT;
            hit_r   <= 1'b0;
            inv_cnt <= 16'd0;
            mv_cnt  <= 2'd0;
            fire_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            px      <= px_nx;
            sx      <= sx_nx;
            sy      <= sy_nx;
            lives_r <= lives_nx;
            hit_r   <= hit_nx;
            inv_cnt <= inv_nx;
            mv_cnt  <= mv_cnt + 2'd1;
            fire_q  <= bus.btn_fire;
        end
    end

    assign bus.player_x      = px;
    assign bus.player_y      = Y_POS;
    assign bus.projectiles_x = sx;
    assign bus.projectiles_y = sy;
    assign bus.hit           = hit_r;
    assign bus.lives         = lives_r;
    assign bus.game_over     = (state == DEAD);
    assign bus.visible       = (state == HIT) ? inv_cnt[3] : 1'b1;
endmodule

// File: tb/tb_player_cannon.sv
// Bench for player_cannon: directed stimulus queues expected snapshots,
// a negedge monitor pops and compares them against the outputs.
module tb_player_cannon;
    logic clk_4 = 1'b0;
    logic clr;

    player_cannon_if pif();

    player_cannon dut (
        .clk_4 (clk_4),
        .clr   (clr),
        .bus   (pif.slave)
    );

    always #5 clk_4 = ~clk_4;

    typedef struct {
        string      nm;
        logic [9:0] px;
        logic [9:0] sx;
        logic [9:0] sy;
        logic [1:0] lv;
        logic       h;
        logic       go;
        logic       vis;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_4);
        #1;
    endtask

    task automatic chk(input string nm, input int px, input int sx, input int sy,
                       input int lv, input int h, input int go, input int vis);
        exp_t e;
        e.nm  = nm;
        e.px  = 10'(px);
        e.sx  = 10'(sx);
        e.sy  = 10'(sy);
        e.lv  = 2'(lv);
        e.h   = 1'(h);
        e.go  = 1'(go);
        e.vis = 1'(vis);
        sb.push_back(e);
    endtask

    always @(negedge clk_4) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (pif.player_x !== e.px || pif.player_y !== 10'd440 ||
                pif.projectiles_x !== e.sx || pif.projectiles_y !== e.sy ||
                pif.lives !== e.lv || pif.hit !== e.h ||
                pif.game_over !== e.go || pif.visible !== e.vis) begin
                errors++;
                $display("FAIL %s: got px=%0d py=%0d sx=%0d sy=%0d lives=%0d hit=%0b go=%0b vis=%0b; want px=%0d py=440 sx=%0d sy=%0d lives=%0d hit=%0b go=%0b vis=%0b",
                         e.nm, pif.player_x, pif.player_y, pif.projectiles_x, pif.projectiles_y,
                         pif.lives, pif.hit, pif.game_over, pif.visible,
                         e.px, e.sx, e.sy, e.lv, e.h, e.go, e.vis);
            end
        end
    end

    initial begin
        clr = 1'b1;
        pif.play = 1'b0;
        pif.btn_left = 1'b0;
        pif.btn_right = 1'b0;
        pif.btn_fire = 1'b0;
        pif.enemy_hit = 1'b0;
        pif.enemy_projectiles_x = 10'd0;
        pif.enemy_projectiles_y = 10'd0;

        cyc(2);  chk("reset", 320, 0, 0, 3, 0, 0, 1);
        clr = 1'b0;
        cyc(3);  chk("idle_hold", 320, 0, 0, 3, 0, 0, 1);
        pif.play = 1'b1;
        cyc(1);

        // movement
        pif.btn_right = 1'b1;
        cyc(40); pif.btn_right = 1'b0;
        chk("move_right40", 330, 0, 0, 3, 0, 0, 1);
        pif.btn_left = 1'b1; pif.btn_right = 1'b1;
        cyc(16); pif.btn_right = 1'b0;
        chk("both_hold", 330, 0, 0, 3, 0, 0, 1);
        cyc(1340);
        chk("left_clamp", 10, 0, 0, 3, 0, 0, 1);
        pif.btn_left = 1'b0; pif.btn_right = 1'b1;
        cyc(760); pif.btn_right = 1'b0;
        chk("right_to_200", 200, 0, 0, 3, 0, 0, 1);

        // fire and flight
        pif.btn_fire = 1'b1;
        cyc(1);   chk("fire_load", 200, 200, 439, 3, 0, 0, 1);
        cyc(1);   chk("fire_step1", 200, 200, 435, 3, 0, 0, 1);
        cyc(1);   chk("fire_step2", 200, 200, 431, 3, 0, 0, 1);
        cyc(107); chk("fire_last", 200, 200, 3, 3, 0, 0, 1);
        cyc(1);   chk("fire_retire_top", 200, 0, 0, 3, 0, 0, 1);
        cyc(5);   chk("no_refire_held", 200, 0, 0, 3, 0, 0, 1);
        pif.btn_fire = 1'b0;

        // enemy_hit retire with simultaneous fire edge
        cyc(1);  pif.btn_fire = 1'b1;
        cyc(1);  chk("fire2_load", 200, 200, 439, 3, 0, 0, 1);
        pif.btn_fire = 1'b0;
        cyc(1);
        pif.btn_fire = 1'b1; pif.enemy_hit = 1'b1;
        cyc(1);  chk("retire_enemy_hit", 200, 0, 0, 3, 0, 0, 1);
        pif.enemy_hit = 1'b0;
        cyc(2);  chk("no_fire_on_retire", 200, 0, 0, 3, 0, 0, 1);
        pif.btn_fire = 1'b0;

        // hit and invulnerability
        pif.btn_right = 1'b1;
        cyc(480); pif.btn_right = 1'b0;
        chk("pos_320", 320, 0, 0, 3, 0, 0, 1);
        pif.enemy_projectiles_x = 10'd325; pif.enemy_projectiles_y = 10'd440;
        cyc(1);    chk("hit_pulse", 320, 0, 0, 2, 1, 0, 1);
        pif.enemy_projectiles_y = 10'd0;
        cyc(1);    chk("hit_one_cycle", 320, 0, 0, 2, 0, 0, 1);
        cyc(7);    chk("blink_off", 320, 0, 0, 2, 0, 0, 0);
        cyc(8);    chk("blink_on", 320, 0, 0, 2, 0, 0, 1);
        pif.enemy_projectiles_x = 10'd320; pif.enemy_projectiles_y = 10'd440;
        cyc(1);    chk("ignored_in_hit", 320, 0, 0, 2, 0, 0, 1);
        pif.enemy_projectiles_y = 10'd0;
        cyc(1006); chk("still_hit", 320, 0, 0, 2, 0, 0, 0);
        cyc(1);    chk("alive_again", 320, 0, 0, 2, 0, 0, 1);
        pif.enemy_projectiles_y = 10'd440;
        cyc(1);    chk("hit2_accepted", 320, 0, 0, 1, 1, 0, 1);
        pif.enemy_projectiles_y = 10'd0;
        cyc(1024); chk("alive_after_hit2", 320, 0, 0, 1, 0, 0, 1);

        // death with a shot in flight
        pif.btn_fire = 1'b1;
        cyc(1);  chk("fire3_load", 320, 320, 439, 1, 0, 0, 1);
        pif.btn_fire = 1'b0;
        pif.enemy_projectiles_x = 10'd318; pif.enemy_projectiles_y = 10'd435;
        cyc(1);  chk("death", 320, 0, 0, 0, 1, 1, 1);
        pif.enemy_projectiles_y = 10'd0;
        pif.btn_left = 1'b1; pif.btn_fire = 1'b1;
        cyc(8);  chk("dead_frozen", 320, 0, 0, 0, 0, 1, 1);
        pif.btn_left = 1'b0; pif.btn_fire = 1'b0; pif.play = 1'b0;
        cyc(1);  chk("idle_after_dead", 320, 0, 0, 3, 0, 0, 1);

        // asynchronous clear mid-HIT
        pif.play = 1'b1;
        cyc(1);
        pif.btn_left = 1'b1;
        cyc(8);  pif.btn_left = 1'b0;
        pif.btn_fire = 1'b1;
        cyc(1);  pif.btn_fire = 1'b0;
        pif.enemy_projectiles_x = 10'd318; pif.enemy_projectiles_y = 10'd440;
        cyc(1);  pif.enemy_projectiles_y = 10'd0;
        cyc(8);  chk("mid_hit", 318, 318, 403, 2, 0, 0, 0);
        cyc(1);  chk("async_clr", 320, 0, 0, 3, 0, 0, 1);
        #2 clr = 1'b1;
        cyc(2);
        clr = 1'b0;
        cyc(2);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/player_cannon.md
PLAYER_CANNON -- requirements
Module: player_cannon

Interface
REQ-001 The block SHALL have these parameters:
- X_MIN, 10, leftmost player_x.
- X_MAX, 630, rightmost player_x.
- Y_POS, 440, fixed player_y.
- PROJ_STEP, 4, projectile upward pixels per clock.
- LIVES_INIT, 3, lives after reset or new game (1..3).
- INVULN_CYCLES, 1024, post-hit invulnerability length in clocks (16-bit).

REQ-002 The block SHALL have these ports:
- clk_4  in  1  game clock; all state on its rising edge.
- clr  in  1  reset.
- play  in  1  game running; 0 = hold in IDLE.
- btn_left  in  1  move-left request, level.
- btn_right  in  1  move-right request, level.
- btn_fire  in  1  fire request; acted on at its rising edge.
- enemy_hit  in  1  OR of invader collision flags; retires player shot.
- enemy_projectiles_x  in  10  enemy shot x.
- enemy_projectiles_y  in  10  enemy shot y; 0 = no shot.
- player_x  out  10  ship centre x.
- player_y  out  10  ship y.
- projectiles_x  out  10  player shot x.
- projectiles_y  out  10  player shot y; 0 = no shot.
- hit  out  1  one-cycle pulse per accepted hit.
- lives  out  2  remaining lives.
- game_over  out  1  high in DEAD.
- visible  out  1  sprite enable (blink during HIT).

REQ-003 Clocking and reset are fixed: one clock, clk_4; reset is clr, asynchronous and active-high.

Function
REQ-004 The block SHALL implement states IDLE, ALIVE, HIT and DEAD.
- play=0 in any state -> IDLE next cycle.
- IDLE with play=1 -> ALIVE.
- ALIVE on accepted hit -> HIT, or DEAD if lives was 1.
- HIT when the invulnerability counter reaches 0 -> ALIVE.
- DEAD is held until play=0.

REQ-005 While in IDLE, the block SHALL hold:
- player_x=(X_MIN+X_MAX)/2, player_y=Y_POS
- lives=LIVES_INIT
- projectiles_x/y=0
- hit=0, game_over=0, visible=1

REQ-006 A free-running 2-bit move counter SHALL gate movement; only in ALIVE/HIT and only when the counter is 3:
- btn_left alone -> player_x-1 if player_x>X_MIN.
- btn_right alone -> player_x+1 if player_x<X_MAX.
- Both buttons or neither -> hold.
- player_x never leaves [X_MIN, X_MAX].

REQ-007 The block SHALL register btn_fire each cycle for edge detection; a rising edge fires only when all hold: state is ALIVE, projectiles_y==0 at that cycle, and no hit is accepted that cycle. A shot loads projectiles_x=player_x and projectiles_y=Y_POS-1.

REQ-008 An active shot (projectiles_y!=0) SHALL update each cycle:
- enemy_hit=1 or projectiles_y<=PROJ_STEP -> projectiles_x/y=0 (retire).
- Otherwise -> projectiles_y-=PROJ_STEP.
- A shot retiring this cycle does not allow a new fire in the same cycle.

REQ-009 A hit is detected when all hold:
- enemy_projectiles_y!=0
- Y_POS-10 <= enemy_projectiles_y <= Y_POS+10
- |enemy_projectiles_x - player_x| < 10

All comparisons SHALL avoid unsigned underflow (compare larger-minus-smaller).

REQ-010 A hit is accepted only in ALIVE; an accepted hit SHALL pulse hit for exactly one cycle, decrement lives and load the invulnerability counter with INVULN_CYCLES-1. Hits in HIT, DEAD or IDLE are ignored.

REQ-011 In HIT, the counter SHALL decrement once per cycle, with visible = counter bit 3; in all other states visible=1.

REQ-012 On entering DEAD, the block SHALL set game_over=1, lives=0 and projectiles_x/y=0; position freezes and fire is ignored.

REQ-013 play falling mid-HIT or mid-flight SHALL take effect next cycle per REQ-005; no pending pulse leaks out.

Reset
REQ-014 clr=1 SHALL immediately force the following, independent of clk_4:
- state IDLE
- player_x=320, player_y=440
- projectiles_x/y=0
- hit=0, lives=3, game_over=0, visible=1
- move counter 0, fire edge register 0, invulnerability counter 0

Verification
REQ-015 Move: play=1, btn_right held 40 cycles from x=320 -> player_x=330; left held from x=10 -> stays 10.
REQ-016 Fire: btn_fire rises at player_x=200 -> next cycle projectiles=(200,439), then 435, 431...; after reaching <=4 -> 0; holding btn_fire high fires no second shot.
REQ-017 Retire: shot in flight, enemy_hit=1 for one cycle -> projectiles_y=0 next cycle; btn_fire edge that same cycle -> no new shot.
REQ-018 Hit: player_x=320, enemy shot at (325,440) -> hit pulse 1 cycle, lives 3->2, state HIT, visible toggles every 8 cycles; a second enemy shot during HIT -> no hit; ALIVE after 1024 cycles.
REQ-019 Death: lives=1, enemy shot at (318,435) -> game_over=1, lives=0, shot cleared; play=0 -> IDLE with lives=3, x=320.
REQ-020 Async reset: clr asserted mid-HIT between clock edges -> all outputs at REQ-014 values before the next edge.
